eth_tx_frame_streamer: RTL

- TX frame staging buffer between the BlackParrot MMIO/config path and the AXIS TX framer.
- Software writes payload words into a local buffer. It then issues a send command carrying size and head offset.
- The block emits a size word followed by the payload words on a valid/yumi stream. That stream is the framer's frame_data_* input.
- Single-frame buffer: writes and new sends are locked out while a frame is streaming.

---
 rtl/eth_tx_frame_streamer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/eth_tx_frame_streamer.sv
// eth_tx_frame_streamer: single-frame TX staging buffer. Software fills a
// word buffer and then issues a send command. The block streams a size word
// followed by the payload words on a valid/yumi interface toward the framer.
// Optional feature macro: ETH_TX_STREAMER_ZERO_PAD_EN. When it is defined,
// payload bytes outside the packet are forced to zero.
module eth_tx_frame_streamer #(
  parameter int buf_words_p  = 256,
  parameter int data_width_p = 64
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           wr_v_i,
  output logic                           wr_ready_o,
  input  logic [$clog2(buf_words_p)-1:0] wr_addr_i,
  input  logic [data_width_p-1:0]        wr_data_i,
  input  logic [data_width_p/8-1:0]      wr_mask_i,
  input  logic                           send_v_i,
  output logic                           send_ready_o,
  input  logic [15:0]                    send_size_i,
  input  logic [2:0]                     send_offset_i,
  output logic                           send_err_o,
  output logic [data_width_p-1:0]        frame_data_o,
  output logic                           frame_data_v_o,
  input  logic                           frame_data_yumi_i,
  output logic                           tx_busy_o,
  output logic                           tx_done_o
);

  localparam int addr_w = $clog2(buf_words_p);
  localparam int lanes = data_width_p / 8;
  localparam logic [17:0] buf_words_l = 18'(buf_words_p);

  typedef enum logic [1:0] {IDLE, SIZE, PAYLOAD} state_t;

  state_t                  state;
  logic [15:0]             size_r;
  logic [2:0]              offset_r;
  logic [addr_w-1:0]       ptr_r;
  logic [addr_w-1:0]       last_ptr_r;
  logic [data_width_p-1:0] mem [buf_words_p];
`ifdef ETH_TX_STREAMER_ZERO_PAD_EN
  logic [2:0]              tail_r;
`endif

  logic [16:0]             total;
  logic [17:0]             nwords;
  logic                    cmd_bad;
  logic [data_width_p-1:0] rd_word;

  // Frame length in words, including the head offset bytes in word 0.
  assign total   = {1'b0, send_size_i} + {14'b0, send_offset_i};
  assign nwords  = ({1'b0, total} + 18'd7) >> 3;
  assign cmd_bad = (send_size_i == 16'd0) || (nwords > buf_words_l);

  assign wr_ready_o     = (state == IDLE);
  assign send_ready_o   = (state == IDLE);
  assign tx_busy_o      = (state != IDLE);
  assign frame_data_v_o = (state != IDLE);

  // Buffer write port: byte-masked, only while idle; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (wr_v_i && wr_ready_o) begin
      for (int b = 0; b < lanes; b++) begin
        if (wr_mask_i[b]) begin
          mem[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  // Combinational read of the current payload word, optionally zero-padded.
  always_comb begin
    rd_word = mem[ptr_r];
`ifdef ETH_TX_STREAMER_ZERO_PAD_EN
    for (int b = 0; b < lanes; b++) begin
      if ((ptr_r == '0 && 3'(b) < offset_r) ||
          (ptr_r == last_ptr_r && tail_r != 3'd0 && 3'(b) >= tail_r)) begin
        rd_word[8*b +: 8] = 8'h00;
      end
    end
`endif
  end

  // Output mux: size word in SIZE, buffer word in PAYLOAD, zero when idle.
  always_comb begin
    frame_data_o = '0;
    case (state)
      SIZE:    frame_data_o = {{(data_width_p-19){1'b0}}, offset_r, size_r};
      PAYLOAD: frame_data_o = rd_word;
      default: frame_data_o = '0;
    endcase
  end

  // Streaming FSM: accepts commands in IDLE and walks size word then payload.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      ptr_r      <= '0;
      last_ptr_r <= '0;
      size_r     <= '0;
      offset_r   <= '0;
      send_err_o <= 1'b0;
      tx_done_o  <= 1'b0;
`ifdef ETH_TX_STREAMER_ZERO_PAD_EN
      tail_r     <= '0;
`endif
    end else begin
      send_err_o <= 1'b0;
      tx_done_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (send_v_i) begin
            if (cmd_bad) begin
              send_err_o <= 1'b1;
            end else begin
              size_r     <= send_size_i;
              offset_r   <= send_offset_i;
              last_ptr_r <= nwords[addr_w-1:0] - {{(addr_w-1){1'b0}}, 1'b1};
`ifdef ETH_TX_STREAMER_ZERO_PAD_EN
              tail_r     <= total[2:0];
`endif
              state      <= SIZE;
            end
          end
        end
        SIZE: begin
          if (frame_data_yumi_i) begin
            ptr_r <= '0;
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (frame_data_yumi_i) begin
            if (ptr_r == last_ptr_r) begin
              state     <= IDLE;
              tx_done_o <= 1'b1;
            end else begin
              ptr_r <= ptr_r + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
